// File: rtl/color_pkg.sv
// Shared types and float-format constants for the pixel/vector color paths.
package color_pkg;

  localparam int unsigned SIZE   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned NUM_CH = 3;

  function automatic int unsigned bias_of(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned mant_w_of(input int unsigned size, input int unsigned exp_w);
    return size - 32'd1 - exp_w;
  endfunction

  localparam int unsigned MANT_W = mant_w_of(SIZE, EXP_W);
  localparam int unsigned BIAS   = bias_of(EXP_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/u8_to_float.sv
// Exact u8 -> float conversion of c * 2^-8: leading-one detect, normalise, pack.
module u8_to_float #(
  parameter int unsigned SIZE  = color_pkg::SIZE,
  parameter int unsigned EXP_W = color_pkg::EXP_W
) (
  input  logic [7:0]      i_c,
  output logic [SIZE-1:0] o_f
);
  import color_pkg::*;

  localparam int unsigned LP_MANT_W = mant_w_of(SIZE, EXP_W);
  localparam int unsigned LP_BIAS   = bias_of(EXP_W);

  logic [2:0]           w_p;
  logic [7:0]           w_norm;
  logic [EXP_W-1:0]     w_exp;
  logic [LP_MANT_W-1:0] w_mant;

  // Highest set bit wins.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_c[i]) w_p = 3'(i);
    end
  end

  // Shift the leading one to bit 7; the seven bits below it become the mantissa MSBs.
  always_comb begin
    w_norm = i_c << (3'd7 - w_p);
    w_exp  = EXP_W'(LP_BIAS - 32'd8) + EXP_W'(w_p);
    w_mant = '0;
    w_mant[LP_MANT_W-1 -: 7] = w_norm[6:0];
    o_f    = (i_c == 8'd0) ? '0 : {1'b0, w_exp, w_mant};
  end

endmodule

// File: rtl/pixel_to_vec_color.sv
// Packed RGB pixel -> three-element float vector, one shared converter over three cycles.
module pixel_to_vec_color #(
  parameter int unsigned SIZE  = color_pkg::SIZE,
  parameter int unsigned EXP_W = color_pkg::EXP_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [23:0]           s_axis_a_tdata,
  input  logic                  s_axis_a_tvalid,
  output logic                  s_axis_a_tready,
  output logic [2:0][SIZE-1:0]  m_axis_result_tdata,
  output logic                  m_axis_result_tvalid,
  input  logic                  m_axis_result_tready
);
  import color_pkg::*;

  state_t                        r_state;
  logic [1:0]                    r_idx;
  logic [NUM_CH*CH_W-1:0]        r_pixel;
  logic [NUM_CH-1:0][SIZE-1:0]   r_tdata;
  logic                          r_tvalid;

  logic                          w_accept;
  logic [CH_W-1:0]               w_chan;
  logic [SIZE-1:0]               w_flt;

  // Ready depends only on registered state and downstream ready.
  always_comb begin
    s_axis_a_tready = !areset &&
                      ((r_state == IDLE) || ((r_state == OUT) && m_axis_result_tready));
    w_accept        = s_axis_a_tvalid && s_axis_a_tready;
  end

  always_comb begin
    case (r_idx)
      2'd1:    w_chan = r_pixel[15:8];
      2'd2:    w_chan = r_pixel[23:16];
      default: w_chan = r_pixel[7:0];
    endcase
  end

  u8_to_float #(
    .SIZE  (SIZE),
    .EXP_W (EXP_W)
  ) u_conv (
    .i_c (w_chan),
    .o_f (w_flt)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_pixel  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pixel <= s_axis_a_tdata;
            r_idx   <= '0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_tdata[r_idx] <= w_flt;
          if (r_idx == 2'd2) begin
            r_idx    <= '0;
            r_tvalid <= 1'b1;
            r_state  <= OUT;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        OUT: begin
          // A new pixel can be taken in the same cycle the result leaves.
          if (m_axis_result_tready) begin
            r_tvalid <= 1'b0;
            if (w_accept) begin
              r_pixel <= s_axis_a_tdata;
              r_idx   <= '0;
              r_state <= CONV;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_result_tdata  = r_tdata;
  assign m_axis_result_tvalid = r_tvalid;

endmodule

// File: doc/pixel_to_vec_color.md
# pixel_to_vec_color

Converts one packed 24-bit RGB pixel into a three-component float color vector, each channel scaled to c·2^-8. It is the inverse of the vector-to-pixel output path and feeds texture and framebuffer readback pixels back into the float shading pipeline. One shared channel converter is time-multiplexed over three cycles. Both sides use AXI-stream style valid/ready handshakes.

## Interface
- SIZE, 32: float word width in bits.
- EXP_W, 8: exponent width. Mantissa width is MANT_W = SIZE-1-EXP_W. Bias is 2^(EXP_W-1)-1. Requires EXP_W ≥ 5 and MANT_W ≥ 7.
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_a_tdata  in  24  pixel. [7:0] is channel 0, [15:8] channel 1, [23:16] channel 2.
- s_axis_a_tvalid  in  1  pixel valid.
- s_axis_a_tready  out  1  block can accept a pixel.
- m_axis_result_tdata  out  [2:0][SIZE-1:0]  float vector; element i is channel i.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream accepts the result.

## Operation
- FSM states:
  - IDLE: waiting for a pixel.
  - CONV: converting; 2-bit channel index idx runs 0..2.
  - OUT: holding a result.
- Ready rule: s_axis_a_tready = !areset && (state==IDLE || (state==OUT && m_axis_result_tready)).
- Pixel accept: occurs when s_axis_a_tvalid && s_axis_a_tready.
  - The pixel is captured into an internal register, so the upstream source may change tdata afterwards.
  - Next state is CONV with idx=0.
- CONV cycle: convert channel idx of the captured pixel and write it into result element idx.
  - When idx<2, increment idx.
  - When idx==2, go to OUT.
- OUT: m_axis_result_tvalid=1 and tdata is held stable until the output handshake.
  - Handshake with no simultaneous accept: go to IDLE.
  - Handshake with a simultaneous accept: go directly to CONV with idx=0 and the new pixel.
- Channel conversion, u8 c to float:
  - c==0 gives all-zero bits.
  - Otherwise, let p be the index of the leading one (0..7). Sign=0. Exponent = bias + p − 8.
  - Mantissa = the p bits below the leading one, left-aligned in MANT_W, low bits zero-filled.
  - The conversion is exact; no rounding.
- Reset: state=IDLE, idx=0, m_axis_result_tvalid=0, m_axis_result_tdata=0, and the captured pixel is cleared.
  - While areset is high, s_axis_a_tready=0.
  - In the first cycle after release, s_axis_a_tready=1.
- Reset mid-operation (CONV or OUT): the in-flight pixel is discarded and never emitted.

## Timing
- Accept in cycle T:
  - CONV runs in T+1, T+2, T+3.
  - m_axis_result_tvalid is first high in cycle T+4.
  - Latency is 4 cycles.
- Sustained throughput with m_axis_result_tready held at 1: one pixel per 4 cycles. The next accept happens in the OUT cycle.
- s_axis_a_tready is low throughout CONV, and low in OUT while m_axis_result_tready=0.
- s_axis_a_tready has a combinational path from m_axis_result_tready and from the registered state only. There is no path from s_axis_a_tvalid.
- m_axis_result_tvalid and m_axis_result_tdata are registered outputs.
- Once m_axis_result_tvalid rises, it does not drop until the output handshake or reset.

## Structure
- Shared package color_pkg provides:
  - the state enum (IDLE, CONV, OUT);
  - SIZE and EXP_W defaults;
  - BIAS and MANT_W as localparam functions of those defaults.
- Sub-module u8_to_float #(SIZE, EXP_W): purely combinational leading-one detect and pack, instantiated once and shared across the three CONV cycles.
- The top level holds the FSM, idx counter, pixel register, and result register.

## Test plan
All expected values use SIZE=32, EXP_W=8.
- Pixel 0x000000 accepted in cycle T → tvalid high at T+4 with all three elements 0x00000000.
- Pixel 0xFF8001 → element 0 = 0x3B800000, element 1 = 0x3F000000, element 2 = 0x3F7F0000.
- Pixel 0x402010 → element 0 = 0x3D800000, element 1 = 0x3E000000, element 2 = 0x3E800000.
- Backpressure: m_axis_result_tready=0 for 10 cycles after tvalid rises, with a second pixel pending →
  - tdata stays stable and tvalid stays 1;
  - s_axis_a_tready stays 0 and the second pixel is not taken;
  - when tready rises, the output handshake and the second pixel's accept occur in the same cycle.
- Streaming: m_axis_result_tready=1 and s_axis_a_tvalid=1 with 5 distinct pixels →
  - accepts occur every 4 cycles;
  - outputs appear in order, each exactly 4 cycles after its accept, with no loss or duplication.
- Reset: assert areset in the second CONV cycle →
  - tvalid stays 0 and no result is ever emitted for that pixel;
  - s_axis_a_tready returns to 1 one cycle after release;
  - the next pixel, 0x0000FF, gives element 0 = 0x3F7F0000.
